// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: drives the AD9244 streaming block's control word, flushes
// its pipeline after enable, and frames its sample stream into fixed-length AXIS
// packets with TLAST. The source cannot be stalled, so a 1-deep output register
// absorbs one sample and anything arriving while it is blocked is counted as a drop.
module adc_capture_sequencer #(
    parameter int C_AXIS_TDATA_WIDTH = 16,
    parameter int C_SETTLE_CYCLES    = 8
) (
    input  logic                          m00_axis_aclk,
    input  logic                          m00_axis_aresetn,
    input  logic                          cfg_start,
    input  logic                          cfg_stop,
    input  logic [15:0]                   cfg_frame_len,
    input  logic [15:0]                   cfg_num_frames,
    input  logic                          cfg_test_mode,
    output logic [3:0]                    adc_control,
    input  logic [31:0]                   adc_status,
    input  logic                          s00_axis_tvalid,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    output logic                          m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    output logic                          busy,
    output logic                          done,
    output logic                          err_cfg,
    output logic                          otr_seen,
    output logic [15:0]                   frames_done,
    output logic [15:0]                   drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        STREAM,
        FLUSH
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(C_SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] frame_len;
    logic [15:0] num_frames;
    logic [15:0] sample_cnt;
    logic [7:0]  settle_cnt;
    logic        stop_pending;

    logic        out_free;
    logic        at_last;
    logic [15:0] frames_next;
    logic        status_unused;

    // Drop counter must stick at all-ones rather than wrap.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Output register can take a new sample when empty or emptying this cycle.
    assign out_free      = !m00_axis_tvalid || m00_axis_tready;
    assign at_last       = (sample_cnt == frame_len - 16'd1);
    assign frames_next   = frames_done + 16'd1;
    // Only the OTR flag is used; overrun is replaced by local drop accounting.
    assign status_unused = ^{adc_status[31:3], adc_status[1:0]};

    // Capture FSM with registered control word, framing register and status counters.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state           <= IDLE;
            frame_len       <= '0;
            num_frames      <= '0;
            sample_cnt      <= '0;
            settle_cnt      <= '0;
            stop_pending    <= 1'b0;
            adc_control     <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_cfg         <= 1'b0;
            otr_seen        <= 1'b0;
            frames_done     <= '0;
            drop_cnt        <= '0;
        end else begin
            done <= 1'b0;
            if (m00_axis_tvalid && m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    adc_control <= {cfg_test_mode, 3'b000};
                    if (cfg_start) begin
                        if (cfg_frame_len == 16'd0) begin
                            err_cfg <= 1'b1;
                        end else begin
                            frames_done  <= '0;
                            drop_cnt     <= '0;
                            otr_seen     <= 1'b0;
                            err_cfg      <= 1'b0;
                            frame_len    <= cfg_frame_len;
                            num_frames   <= cfg_num_frames;
                            sample_cnt   <= '0;
                            settle_cnt   <= '0;
                            stop_pending <= 1'b0;
                            busy         <= 1'b1;
                            adc_control  <= {cfg_test_mode, 3'b110};
                            state        <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    if (cfg_stop) begin
                        adc_control <= {cfg_test_mode, 3'b000};
                        state       <= FLUSH;
                    end else begin
                        adc_control <= {cfg_test_mode, 3'b001};
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    adc_control <= {cfg_test_mode, 3'b001};
                    if (cfg_stop) begin
                        adc_control <= {cfg_test_mode, 3'b000};
                        state       <= FLUSH;
                    end else if (s00_axis_tvalid) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= STREAM;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                end
                STREAM: begin
                    adc_control <= {cfg_test_mode, 3'b001};
                    if (adc_status[2]) begin
                        otr_seen <= 1'b1;
                    end
                    if (cfg_stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (s00_axis_tvalid) begin
                        if (out_free) begin
                            m00_axis_tvalid <= 1'b1;
                            m00_axis_tdata  <= s00_axis_tdata;
                            m00_axis_tlast  <= at_last;
                            if (at_last) begin
                                sample_cnt  <= '0;
                                frames_done <= frames_next;
                                if (stop_pending || cfg_stop ||
                                    (num_frames != 16'd0 && frames_next == num_frames)) begin
                                    adc_control <= {cfg_test_mode, 3'b000};
                                    state       <= FLUSH;
                                end
                            end else begin
                                sample_cnt <= sample_cnt + 16'd1;
                            end
                        end else begin
                            drop_cnt <= sat_inc16(drop_cnt);
                        end
                    end
                end
                FLUSH: begin
                    adc_control <= {cfg_test_mode, 3'b000};
                    if (out_free) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        stop_pending <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Testbench for adc_capture_sequencer: a per-cycle reference of the capture rules
// pushes expected output beats into a queue; an independent monitor pops and
// compares them on every output handshake and watches stall stability and done.
module tb_adc_capture_sequencer;

    localparam int W      = 16;
    localparam int SETTLE = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [15:0]   cfg_frame_len = '0;
    logic [15:0]   cfg_num_frames = '0;
    logic          cfg_test_mode = 1'b0;
    logic [3:0]    adc_control;
    logic [31:0]   adc_status = '0;
    logic          s00_axis_tvalid = 1'b0;
    logic [W-1:0]  s00_axis_tdata = '0;
    logic          m00_axis_tvalid;
    logic [W-1:0]  m00_axis_tdata;
    logic          m00_axis_tlast;
    logic          m00_axis_tready = 1'b1;
    logic          busy;
    logic          done;
    logic          err_cfg;
    logic          otr_seen;
    logic [15:0]   frames_done;
    logic [15:0]   drop_cnt;

    int            checks = 0;
    int            errors = 0;
    int            done_seen = 0;
    logic [16:0]   exp_q[$];

    always #5 clk = ~clk;

    adc_capture_sequencer #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_SETTLE_CYCLES(SETTLE)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_aresetn(rst_n),
        .cfg_start(cfg_start),
        .cfg_stop(cfg_stop),
        .cfg_frame_len(cfg_frame_len),
        .cfg_num_frames(cfg_num_frames),
        .cfg_test_mode(cfg_test_mode),
        .adc_control(adc_control),
        .adc_status(adc_status),
        .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tdata(s00_axis_tdata),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tready(m00_axis_tready),
        .busy(busy),
        .done(done),
        .err_cfg(err_cfg),
        .otr_seen(otr_seen),
        .frames_done(frames_done),
        .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on handshake, hold check while stalled, count done pulses.
    initial begin
        logic        stalled;
        logic [16:0] held;
        logic [16:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (done) done_seen++;
                if (stalled) begin
                    check("stall_hold", 32'({m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata}),
                          32'({1'b1, held}));
                end
                if (m00_axis_tvalid && m00_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected actual=%0h required=none",
                                 {m00_axis_tlast, m00_axis_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 32'({m00_axis_tlast, m00_axis_tdata}), 32'(e));
                    end
                    stalled = 1'b0;
                end else if (m00_axis_tvalid) begin
                    stalled = 1'b1;
                    held    = {m00_axis_tlast, m00_axis_tdata};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // One capture. mode 0: back-to-back, tready=1, data=cycle. mode 1: directed stall.
    // mode 2: random valid/ready/data. abort_at>=0 resets the DUT mid-stream at that cycle.
    task automatic capture(input int len, input int nf, input int mode, input int stop_frame,
                           input bit otr_test, input int abort_at);
        int          ph;      // 1 settling, 2 streaming, 3 flushing, 0 finished
        int          settle_n, k, frames, drops, done_before;
        bit          full, stop_p, v, tr, stop, acc, last, tm;
        logic [15:0] d;
        ph = 1; settle_n = 0; k = 0; frames = 0; drops = 0;
        full = 0; stop_p = 0;
        tm = 1'($urandom_range(0, 1));
        done_before = done_seen;

        cfg_frame_len  = 16'(len);
        cfg_num_frames = 16'(nf);
        cfg_test_mode  = tm;
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("clear_ctrl", 32'(adc_control), 32'({tm, 3'b110}));
        check("busy_start", 32'(busy), 32'd1);
        check("err_clear", 32'(err_cfg), 32'd0);
        tick();
        check("settle_ctrl", 32'(adc_control), 32'({tm, 3'b001}));

        for (int cyc = 0; cyc < 3000 && ph != 0; cyc++) begin
            case (mode)
                0: begin v = 1; tr = 1; d = 16'(cyc); end
                1: begin v = (cyc != 9); tr = !(cyc >= 10 && cyc <= 12); d = 16'(cyc); end
                default: begin
                    v  = ($urandom_range(0, 9) < 7);
                    tr = ($urandom_range(0, 9) < 7);
                    d  = 16'($urandom);
                end
            endcase
            stop = (stop_frame > 0 && ph == 2 && frames == stop_frame - 1 && k == 1);
            if (abort_at >= 0 && cyc == abort_at) tr = 0;
            s00_axis_tvalid = v;
            s00_axis_tdata  = d;
            m00_axis_tready = tr;
            cfg_stop        = stop;
            adc_status      = $urandom;
            adc_status[2]   = otr_test && (cyc == 2 || cyc == 12);
            if (!otr_test) adc_status[2] = 1'b0;

            if (abort_at >= 0 && cyc == abort_at) begin
                tick();
                check("full_before_reset", 32'(m00_axis_tvalid), 32'd1);
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_ctrl", 32'(adc_control), 32'd0);
                check("rst_tvalid", 32'(m00_axis_tvalid), 32'd0);
                check("rst_frames", 32'(frames_done), 32'd0);
                check("rst_drops", 32'(drop_cnt), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                exp_q.delete();
                s00_axis_tvalid = 1'b0;
                m00_axis_tready = 1'b1;
                cfg_stop        = 1'b0;
                adc_status      = '0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                tick();
                check("post_rst_idle", 32'({busy, adc_control[0]}), 32'd0);
                return;
            end

            acc = 0;
            case (ph)
                1: if (v) begin
                    settle_n++;
                    if (settle_n == SETTLE) ph = 2;
                end
                2: begin
                    if (v) begin
                        if (!full || tr) begin
                            acc  = 1;
                            last = (k == len - 1);
                            exp_q.push_back({last, d});
                            if (last) begin
                                frames++;
                                k = 0;
                                if (stop_p || stop || (nf != 0 && (frames % 65536) == nf)) ph = 3;
                            end else begin
                                k++;
                            end
                        end else if (drops < 65535) begin
                            drops++;
                        end
                    end
                    if (stop) stop_p = 1;
                end
                3: if (!full || tr) ph = 0;
                default: ;
            endcase
            full = acc || (full && !tr);
            tick();
            if (otr_test && cyc == 5) check("otr_settle", 32'(otr_seen), 32'd0);
        end

        if (ph != 0) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout actual=phase%0d required=finished", ph);
        end
        s00_axis_tvalid = 1'b0;
        m00_axis_tready = 1'b1;
        cfg_stop        = 1'b0;
        adc_status      = '0;
        tick();
        tick();
        check("done_once", 32'(done_seen - done_before), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("enable_end", 32'(adc_control[0]), 32'd0);
        check("frames", 32'(frames_done), 32'(frames % 65536));
        check("drops", 32'(drop_cnt), 32'(drops));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        if (otr_test) check("otr_stream", 32'(otr_seen), 32'd1);
    endtask

    initial begin
        #12;
        check("reset_outputs",
              32'({adc_control, m00_axis_tvalid, m00_axis_tlast, busy, done, err_cfg, otr_seen}), 32'd0);
        check("reset_counters", 32'({frames_done, drop_cnt}), 32'd0);
        check("reset_tdata", 32'(m00_axis_tdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two frames of four, no backpressure: beats 8..15, tlast on 11 and 15.
        capture(4, 2, 0, 0, 0, -1);
        check("t1_frames", 32'(frames_done), 32'd2);
        check("t1_drops", 32'(drop_cnt), 32'd0);

        // Stall three cycles mid-frame with the register empty beforehand: two drops.
        capture(4, 2, 1, 0, 0, -1);
        check("t2_drops", 32'(drop_cnt), 32'd2);

        // Continuous mode stopped on the 2nd sample of frame 5.
        capture(3, 0, 0, 5, 0, -1);
        check("t3_frames", 32'(frames_done), 32'd5);

        // OTR pulses in SETTLE (ignored) and STREAM (sticky).
        capture(4, 2, 0, 0, 1, -1);

        // Illegal start: zero frame length.
        cfg_frame_len = 16'd0;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        check("err_cfg_set", 32'(err_cfg), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_no_enable", 32'(adc_control[0]), 32'd0);
        end
        capture(2, 1, 2, 0, 0, -1);

        // Reset mid-stream with the output register full, then a fresh capture.
        capture(2, 0, 0, 0, 0, 20);
        capture(3, 2, 0, 0, 0, -1);

        // Randomized captures.
        for (int i = 0; i < 6; i++) begin
            capture($urandom_range(1, 6), $urandom_range(1, 3), 2, 0, 0, -1);
        end
        capture($urandom_range(2, 5), 0, 2, 2, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Sequences one AD9244 ADC-to-AXIS streaming block for a capture: drives its 4-bit control word, flushes its pipeline and frames its sample stream into fixed-length AXIS packets with TLAST for the downstream DMA.
- Sits between the ADC streaming block and the DMA S2MM port; configured by the PS through an AXI-Lite register block.
- The ADC source has no backpressure, so the sequencer buffers one sample and counts dropped samples.

Parameters:
- C_AXIS_TDATA_WIDTH, 16, sample width on both streams.
- C_SETTLE_CYCLES, 8, samples discarded after streamEnable rises (ADC pipeline flush); range 1..255.

Ports:
- m00_axis_aclk  in  1  single clock.
- m00_axis_aresetn  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle start pulse.
- cfg_stop  in  1  one-cycle stop pulse; takes effect at the next frame boundary.
- cfg_frame_len  in  16  samples per frame; 0 is illegal.
- cfg_num_frames  in  16  frames per capture; 0 means continuous until stop.
- cfg_test_mode  in  1  passed to adc_control[3].
- adc_control  out  4  to the ADC block: [0] streamEnable, [1] clearOverRun, [2] clearOTR, [3] testMode.
- adc_status  in  32  from the ADC block: [1] overrun, [2] OTR; other bits ignored.
- s00_axis_tvalid  in  1  sample valid from the ADC block.
- s00_axis_tdata  in  16  sample data.
- m00_axis_tvalid  out  1  framed stream to the DMA.
- m00_axis_tdata  out  16  framed stream data.
- m00_axis_tlast  out  1  asserted on the last sample of each frame.
- m00_axis_tready  in  1  downstream ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- err_cfg  out  1  sticky; set when start is rejected.
- otr_seen  out  1  sticky; set when adc_status[2]=1 in STREAM.
- frames_done  out  16  completed frames, wraps.
- drop_cnt  out  16  dropped samples, saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-low): every output 0, state IDLE, all counters 0, output register empty.
- States: IDLE, CLEAR, SETTLE, STREAM, FLUSH.
- IDLE:
  - adc_control = {cfg_test_mode, 3'b000}.
  - cfg_start with cfg_frame_len != 0: clear frames_done, drop_cnt, otr_seen and err_cfg; latch cfg_frame_len and cfg_num_frames; go to CLEAR.
  - cfg_start with cfg_frame_len = 0: set err_cfg, stay in IDLE.
  - cfg_start outside IDLE is ignored.
- CLEAR: exactly 1 cycle with adc_control[2:1] = 2'b11 and [0] = 0; then go to SETTLE.
- SETTLE:
  - adc_control[0] = 1.
  - Count s00_axis_tvalid beats, discarding them.
  - After C_SETTLE_CYCLES beats, go to STREAM.
- STREAM:
  - adc_control[0] = 1.
  - Each s00_axis_tvalid beat loads a 1-deep output register when it is empty or drains that cycle (m00_axis_tready=1); otherwise the sample is dropped and drop_cnt increments.
  - Dropped samples do not advance the sample counter.
  - The sample counter counts accepted samples. The sample loaded when the count equals frame_len-1 carries tlast=1; the counter then resets to 0 and frames_done increments.
  - Latency: a sample accepted in cycle N is visible on m00_axis_tdata in cycle N+1.
  - At a frame boundary (tlast sample loaded), go to FLUSH if stop is pending or frames_done+1 equals a nonzero num_frames.
  - cfg_stop in STREAM latches stop-pending. A stop and a frame boundary in the same cycle count as pending.
- FLUSH:
  - adc_control[0] = 0; incoming samples are ignored and not counted as drops.
  - When the output register is empty or drains that cycle, go to IDLE, pulse done, clear stop-pending.
- cfg_stop in CLEAR or SETTLE: go straight to FLUSH; no frames are emitted.
- otr_seen is sampled only in STREAM.
- adc_status[1] is ignored: the sequencer does its own drop accounting.
- AXIS rules: tvalid and tdata stay stable until tready; tlast stays coupled to its sample.
- frames_done wraps at 0xFFFF→0; in continuous mode the wrap does not terminate the capture.
- drop_cnt saturates at 0xFFFF.

Test Plan:
- frame_len=4, num_frames=2, tready=1, 20 back-to-back samples 0..19 → CLEAR asserts control=0b0110 for 1 cycle. Samples 0..7 are discarded in SETTLE. The output stream is samples 8..15 with tlast on 11 and 15. frames_done=2, done pulses once, control[0] falls after the 8th output, drop_cnt=0.
- Same setup with tready held low for 3 cycles mid-frame → exactly 2 samples dropped, drop_cnt=2. The frame still has 4 beats with tlast on the 4th. tvalid and tdata stay stable while stalled.
- num_frames=0, frame_len=3, cfg_stop pulsed on the 2nd sample of frame 5 → frame 5 completes with its tlast, then FLUSH and IDLE. frames_done=5, done pulses once.
- cfg_start with frame_len=0 → err_cfg=1, busy stays 0, control[0] never rises. A following valid start clears err_cfg.
- Reset asserted mid-STREAM with the output register full → in the same cycle adc_control=0, m00_axis_tvalid=0, counters=0. After release the block is IDLE and a fresh start works.
- adc_status[2]=1 pulsed during SETTLE, then again during STREAM → otr_seen stays 0 after the SETTLE pulse and becomes 1 and stays set after the STREAM pulse.
